// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instruction} pairs between a registered instruction memory and decode.
// Latency: request in cycle N, response enqueued at end of N+1, head visible in N+2; 1 instr/cycle steady state.
// Backpressure: stall holds the head; requests stop once queued plus in-flight entries reach DEPTH.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic                       inst_valid,
    output logic [XLEN-1:0]            inst,
    output logic [XLEN-1:0]            inst_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [XLEN-1:0]  inst_q [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             inflight;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc;
    logic [CNT_W:0]   occupancy;
    logic             enq;
    logic             deq;

    // Counting the in-flight request as occupied guarantees its response always has a slot.
    assign occupancy  = {1'b0, cnt} + {{CNT_W{1'b0}}, inflight};
    assign imem_req   = !reset && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_addr  = fetch_pc;

    assign empty      = (cnt == '0);
    assign full       = (cnt == CNT_W'(DEPTH));
    assign count      = cnt;
    assign inst_valid = !empty;
    assign inst       = inst_q[rd_ptr];
    assign inst_pc    = pc_q[rd_ptr];

    // A response landing in a redirect cycle belongs to the abandoned path.
    assign enq = inflight && !reset && !redirect;
    assign deq = inst_valid && !stall && !redirect && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                req_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cnt      <= '0;
            end else begin
                if (imem_req) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (enq) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({enq, deq})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
            end
            assert (!(enq && full)) else $error("fetch_queue: enqueue into full queue");
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            inst_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= req_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: a queue-level reference model predicts every
// dequeued {pc, inst}, request and occupancy; a second instance covers a wrapping RESET_PC.
module tb_fetch_queue;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2 = '0;
    logic        inst_valid2;
    logic [31:0] inst2;
    logic [31:0] inst_pc2;
    logic [2:0]  count2;
    logic        full2;
    logic        empty2;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .count(count), .full(full), .empty(empty)
    );

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
        .count(count2), .full(full2), .empty(empty2)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        sb[$];
    ent_t        pend;
    bit          pend_v  = 1'b0;
    bit          exp_req = 1'b0;
    bit          armed   = 1'b0;
    bit          mode    = 1'b0;
    logic [31:0] exp_pc  = RST_PC;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a, input bit m);
        return m ? ({a[15:0], a[31:16]} ^ 32'h5A5A_3C3C) : a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory and model producer: responses that survive become expected queue entries.
    always @(posedge clk) begin
        if (reset) begin
            sb.delete();
            pend_v = 1'b0;
            exp_pc = RST_PC;
            armed  = 1'b1;
        end else if (redirect) begin
            sb.delete();
            pend_v = 1'b0;
            exp_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pend_v) sb.push_back(pend);
            pend_v = exp_req;
            if (exp_req) begin
                pend   = '{pc: exp_pc, data: mem_f(exp_pc, mode)};
                exp_pc = exp_pc + 32'd4;
            end
        end
        imem_rdata  <= imem_req ? mem_f(imem_addr, mode) : $urandom();
        imem_rdata2 <= imem_addr2;
    end

    // Monitor: checks outputs mid-cycle and retires the head when the consumer takes it.
    always @(negedge clk) begin
        if (armed) begin
            exp_req = !reset && !redirect && ((sb.size() + int'(pend_v)) < DEPTH);
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", imem_addr, exp_pc);
            chk("count", 32'(count), 32'(sb.size()));
            chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
            chk("full", 32'(full), 32'(sb.size() == DEPTH));
            chk("empty", 32'(empty), 32'(sb.size() == 0));
            if (sb.size() != 0) begin
                chk("inst_pc", inst_pc, sb[0].pc);
                chk("inst", inst, sb[0].data);
                if (!stall && !redirect && !reset) void'(sb.pop_front());
            end
        end
    end

    logic [31:0] wrap_pcs [4];
    logic [31:0] seq_pcs  [4];

    initial begin
        wrap_pcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        seq_pcs  = '{32'h0, 32'h4, 32'h8, 32'hC};

        // Reset release latency and contiguous fetch, including PC wrap on the second instance.
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("n_req", 32'(imem_req), 32'd1);
        chk("n_addr", imem_addr, RST_PC);
        chk("n_valid", 32'(inst_valid), 32'd0);
        step();
        chk("n1_valid", 32'(inst_valid), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("seq_valid", 32'(inst_valid), 32'd1);
            chk("seq_pc", inst_pc, seq_pcs[k]);
            chk("seq_inst", inst, seq_pcs[k]);
            chk("wrap_pc", inst_pc2, wrap_pcs[k]);
            chk("wrap_inst", inst2, wrap_pcs[k]);
            step();
        end
        repeat (6) step();

        // Long stall fills the queue and freezes fetch.
        stall = 1'b1;
        repeat (10) step();
        chk("stall_full", 32'(full), 32'd1);
        chk("stall_count", 32'(count), 32'd4);
        chk("stall_req", 32'(imem_req), 32'd0);
        stall = 1'b0;
        repeat (10) step();

        // Redirect with three entries queued and an unaligned target.
        stall = 1'b1;
        for (int i = 0; i < 10 && count != 3'd3; i++) step();
        chk("reach_count3", 32'(count), 32'd3);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        #1;
        chk("rd1_count", 32'(count), 32'd0);
        chk("rd1_req", 32'(imem_req), 32'd1);
        chk("rd1_addr", imem_addr, 32'h0000_0100);
        step();
        chk("rd2_valid", 32'(inst_valid), 32'd0);
        step();
        chk("rd3_valid", 32'(inst_valid), 32'd1);
        chk("rd3_pc", inst_pc, 32'h0000_0100);
        chk("rd3_inst", inst, 32'h0000_0100);
        repeat (5) step();

        // Random traffic against the reference model.
        mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            stall    = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 96) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom();
            step();
        end
        reset    = 1'b0;
        redirect = 1'b0;
        mode     = 1'b0;

        // Reset while full.
        stall = 1'b1;
        for (int i = 0; i < 12 && !full; i++) step();
        chk("pre_rst_full", 32'(full), 32'd1);
        reset = 1'b1;
        step();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, RST_PC);
        stall = 1'b0;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
